// File: rtl/wb_stage_pipe.sv
// rtl/wb_stage_pipe.sv - registered MEM/WB stage: result select, sub-word load extract, stall/flush, retire counter
// Optional WB_FWD_EN adds combinational fwd_data/fwd_dest/fwd_we mirrors of the write-back port.
module wb_stage_pipe #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_alu_result,
  input  logic [DATA_W-1:0]     in_mem_data,
  input  logic [DATA_W-1:0]     in_pc_plus4,
  input  logic [1:0]            in_sel,
  input  logic [2:0]            in_load_type,
  input  logic [1:0]            in_byte_off,
  input  logic                  in_reg_write,
  input  logic [REG_ADDR_W-1:0] in_dest_reg,
  output logic [DATA_W-1:0]     wb_data,
  output logic [REG_ADDR_W-1:0] wb_dest,
  output logic                  wb_we,
  output logic                  wb_valid,
  output logic                  wb_misaligned,
  output logic [CNT_W-1:0]      retired_count
`ifdef WB_FWD_EN
  ,
  output logic [DATA_W-1:0]     fwd_data,
  output logic [REG_ADDR_W-1:0] fwd_dest,
  output logic                  fwd_we
`endif
);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_MEM  = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  localparam logic [2:0] LD_WORD = 3'b000;
  localparam logic [2:0] LD_BS   = 3'b001;
  localparam logic [2:0] LD_BU   = 3'b010;
  localparam logic [2:0] LD_HS   = 3'b011;
  localparam logic [2:0] LD_HU   = 3'b100;

  logic [DATA_W-1:0]     wb_data_q, wb_data_d;
  logic [REG_ADDR_W-1:0] wb_dest_q, wb_dest_d;
  logic                  wb_we_q, wb_we_d;
  logic                  wb_valid_q, wb_valid_d;
  logic                  wb_misaligned_q, wb_misaligned_d;
  logic [CNT_W-1:0]      retired_count_q, retired_count_d;

  logic [7:0]        byte_lane;
  logic [15:0]       half_lane;
  logic [DATA_W-1:0] mem_ext;
  logic [DATA_W-1:0] result;
  logic              is_half;
  logic              misaligned;

  // Lanes always come from the low 32 bits, even on wider datapaths.
  always_comb begin
    byte_lane = 8'h00;
    case (in_byte_off)
      2'd0: byte_lane = in_mem_data[7:0];
      2'd1: byte_lane = in_mem_data[15:8];
      2'd2: byte_lane = in_mem_data[23:16];
      2'd3: byte_lane = in_mem_data[31:24];
      default: byte_lane = in_mem_data[7:0];
    endcase
    half_lane = in_byte_off[1] ? in_mem_data[31:16] : in_mem_data[15:0];
  end

  always_comb begin
    mem_ext = in_mem_data;
    case (in_load_type)
      LD_BS:   mem_ext = {{(DATA_W-8){byte_lane[7]}}, byte_lane};
      LD_BU:   mem_ext = {{(DATA_W-8){1'b0}}, byte_lane};
      LD_HS:   mem_ext = {{(DATA_W-16){half_lane[15]}}, half_lane};
      LD_HU:   mem_ext = {{(DATA_W-16){1'b0}}, half_lane};
      LD_WORD: mem_ext = in_mem_data;
      default: mem_ext = in_mem_data;
    endcase
  end

  assign is_half    = (in_load_type == LD_HS) || (in_load_type == LD_HU);
  assign misaligned = (in_sel == SEL_MEM) && is_half && in_byte_off[0];

  always_comb begin
    result = '0;
    case (in_sel)
      SEL_ALU:  result = in_alu_result;
      SEL_MEM:  result = misaligned ? '0 : mem_ext;
      SEL_PC4:  result = in_pc_plus4;
      SEL_ZERO: result = '0;
      default:  result = '0;
    endcase
  end

  // Priority below reset: flush > stall > load.
  always_comb begin
    wb_data_d       = wb_data_q;
    wb_dest_d       = wb_dest_q;
    wb_we_d         = wb_we_q;
    wb_valid_d      = wb_valid_q;
    wb_misaligned_d = wb_misaligned_q;
    retired_count_d = retired_count_q;
    if (flush_i) begin
      wb_data_d       = '0;
      wb_dest_d       = '0;
      wb_we_d         = 1'b0;
      wb_valid_d      = 1'b0;
      wb_misaligned_d = 1'b0;
    end else if (!stall_i) begin
      wb_data_d       = result;
      wb_dest_d       = in_dest_reg;
      wb_valid_d      = in_valid;
      wb_misaligned_d = in_valid && misaligned;
      wb_we_d         = in_valid && in_reg_write && (in_dest_reg != '0) && !misaligned;
      if (in_valid) begin
        retired_count_d = retired_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_data_q       <= '0;
      wb_dest_q       <= '0;
      wb_we_q         <= 1'b0;
      wb_valid_q      <= 1'b0;
      wb_misaligned_q <= 1'b0;
      retired_count_q <= '0;
    end else begin
      wb_data_q       <= wb_data_d;
      wb_dest_q       <= wb_dest_d;
      wb_we_q         <= wb_we_d;
      wb_valid_q      <= wb_valid_d;
      wb_misaligned_q <= wb_misaligned_d;
      retired_count_q <= retired_count_d;
    end
  end

  assign wb_data       = wb_data_q;
  assign wb_dest       = wb_dest_q;
  assign wb_we         = wb_we_q;
  assign wb_valid      = wb_valid_q;
  assign wb_misaligned = wb_misaligned_q;
  assign retired_count = retired_count_q;

`ifdef WB_FWD_EN
  // A stalled write is already visible downstream; suppress re-forwarding it.
  assign fwd_data = wb_data_q;
  assign fwd_dest = wb_dest_q;
  assign fwd_we   = wb_we_q & ~stall_i;
`endif

endmodule

// File: tb/tb_wb_stage_pipe.sv
// tb/tb_wb_stage_pipe.sv - directed self-checking bench for wb_stage_pipe (CNT_W=4 to reach counter wrap)
module tb_wb_stage_pipe;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  stall_i;
  logic                  flush_i;
  logic                  in_valid;
  logic [DATA_W-1:0]     in_alu_result;
  logic [DATA_W-1:0]     in_mem_data;
  logic [DATA_W-1:0]     in_pc_plus4;
  logic [1:0]            in_sel;
  logic [2:0]            in_load_type;
  logic [1:0]            in_byte_off;
  logic                  in_reg_write;
  logic [REG_ADDR_W-1:0] in_dest_reg;
  logic [DATA_W-1:0]     wb_data;
  logic [REG_ADDR_W-1:0] wb_dest;
  logic                  wb_we;
  logic                  wb_valid;
  logic                  wb_misaligned;
  logic [CNT_W-1:0]      retired_count;

  int errors = 0;
  int checks = 0;

  wb_stage_pipe #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
    .in_valid(in_valid), .in_alu_result(in_alu_result), .in_mem_data(in_mem_data),
    .in_pc_plus4(in_pc_plus4), .in_sel(in_sel), .in_load_type(in_load_type),
    .in_byte_off(in_byte_off), .in_reg_write(in_reg_write), .in_dest_reg(in_dest_reg),
    .wb_data(wb_data), .wb_dest(wb_dest), .wb_we(wb_we), .wb_valid(wb_valid),
    .wb_misaligned(wb_misaligned), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] sel, input logic [2:0] lt,
                       input logic [1:0] off, input logic rw, input logic [4:0] dst);
    in_valid     = v;
    in_sel       = sel;
    in_load_type = lt;
    in_byte_off  = off;
    in_reg_write = rw;
    in_dest_reg  = dst;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] d, input logic [4:0] dst,
                         input logic we, input logic v, input logic mis, input logic [3:0] cnt);
    chk({tag, ".data"}, wb_data, d);
    chk({tag, ".dest"}, {27'd0, wb_dest}, {27'd0, dst});
    chk({tag, ".we"}, {31'd0, wb_we}, {31'd0, we});
    chk({tag, ".valid"}, {31'd0, wb_valid}, {31'd0, v});
    chk({tag, ".mis"}, {31'd0, wb_misaligned}, {31'd0, mis});
    chk({tag, ".cnt"}, {28'd0, retired_count}, {28'd0, cnt});
  endtask

  initial begin
    reset = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    in_alu_result = 32'h1111_2222; in_mem_data = 32'h8899_AABB; in_pc_plus4 = 32'h0040_0010;
    drive(1'b1, 2'b00, 3'b000, 2'd0, 1'b1, 5'd9);
    tick(); tick();
    chk_out("reset", 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0);

    reset = 1'b0;
    in_alu_result = 32'h1234_5678;
    drive(1'b1, 2'b00, 3'b000, 2'd0, 1'b1, 5'd3);
    tick();
    chk_out("alu", 32'h1234_5678, 5'd3, 1'b1, 1'b1, 1'b0, 4'd1);

    drive(1'b1, 2'b01, 3'b001, 2'd2, 1'b1, 5'd4);
    tick();
    chk_out("lb_off2", 32'hFFFF_FF99, 5'd4, 1'b1, 1'b1, 1'b0, 4'd2);

    drive(1'b1, 2'b01, 3'b010, 2'd2, 1'b1, 5'd4);
    tick();
    chk_out("lbu_off2", 32'h0000_0099, 5'd4, 1'b1, 1'b1, 1'b0, 4'd3);

    drive(1'b1, 2'b01, 3'b011, 2'd0, 1'b1, 5'd4);
    tick();
    chk_out("lh_off0", 32'hFFFF_AABB, 5'd4, 1'b1, 1'b1, 1'b0, 4'd4);

    drive(1'b1, 2'b01, 3'b100, 2'd1, 1'b1, 5'd5);
    tick();
    chk_out("lhu_mis", 32'h0, 5'd5, 1'b0, 1'b1, 1'b1, 4'd5);

    drive(1'b1, 2'b01, 3'b000, 2'd3, 1'b1, 5'd6);
    tick();
    chk_out("lw_off3", 32'h8899_AABB, 5'd6, 1'b1, 1'b1, 1'b0, 4'd6);

    drive(1'b1, 2'b01, 3'b100, 2'd2, 1'b1, 5'd6);
    tick();
    chk_out("lhu_off2", 32'h0000_8899, 5'd6, 1'b1, 1'b1, 1'b0, 4'd7);

    drive(1'b1, 2'b01, 3'b001, 2'd1, 1'b1, 5'd6);
    tick();
    chk_out("lb_off1", 32'hFFFF_FFAA, 5'd6, 1'b1, 1'b1, 1'b0, 4'd8);

    drive(1'b1, 2'b10, 3'b000, 2'd0, 1'b1, 5'd31);
    tick();
    chk_out("pc4_r31", 32'h0040_0010, 5'd31, 1'b1, 1'b1, 1'b0, 4'd9);

    drive(1'b1, 2'b10, 3'b000, 2'd0, 1'b1, 5'd0);
    tick();
    chk_out("pc4_r0", 32'h0040_0010, 5'd0, 1'b0, 1'b1, 1'b0, 4'd10);

    drive(1'b1, 2'b11, 3'b000, 2'd0, 1'b1, 5'd2);
    tick();
    chk_out("zero", 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 4'd11);

    drive(1'b0, 2'b01, 3'b100, 2'd1, 1'b1, 5'd2);
    tick();
    chk("bubble.valid", {31'd0, wb_valid}, 32'd0);
    chk("bubble.we", {31'd0, wb_we}, 32'd0);
    chk("bubble.mis", {31'd0, wb_misaligned}, 32'd0);
    chk("bubble.cnt", {28'd0, retired_count}, 32'd11);

    in_alu_result = 32'hCAFE_F00D;
    drive(1'b1, 2'b00, 3'b000, 2'd0, 1'b1, 5'd7);
    tick();
    chk_out("pre_stall", 32'hCAFE_F00D, 5'd7, 1'b1, 1'b1, 1'b0, 4'd12);

    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_alu_result = 32'h0BAD_0000 + 32'(i);
      drive(1'b1, 2'b00, 3'b000, 2'd0, 1'b1, 5'(10 + i));
      tick();
      chk_out("stall", 32'hCAFE_F00D, 5'd7, 1'b1, 1'b1, 1'b0, 4'd12);
    end

    flush_i = 1'b1;
    tick();
    chk_out("flush_stall", 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd12);
    flush_i = 1'b0;
    stall_i = 1'b0;

    drive(1'b1, 2'b00, 3'b000, 2'd0, 1'b1, 5'd8);
    tick();
    chk_out("pre_rst", 32'h0BAD_0002, 5'd8, 1'b1, 1'b1, 1'b0, 4'd13);
    stall_i = 1'b1;
    reset = 1'b1;
    tick();
    chk_out("rst_in_stall", 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    reset = 1'b0;
    stall_i = 1'b0;

    drive(1'b1, 2'b00, 3'b000, 2'd0, 1'b0, 5'd1);
    for (int i = 1; i <= 17; i++) begin
      tick();
      if (i == 15) chk("cnt_15", {28'd0, retired_count}, 32'd15);
      if (i == 16) chk("cnt_wrap0", {28'd0, retired_count}, 32'd0);
    end
    chk("cnt_wrap1", {28'd0, retired_count}, 32'd1);
    chk("norw.we", {31'd0, wb_we}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
